// File: rtl/fp_round_seq.sv
// rtl/fp_round_seq.sv - sequential two's-complement to sign/exponent/significand rounding stage
module fp_round_seq #(
  parameter int FRAC_W = 4,
  parameter int EXP_W  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [1+FRAC_W+(2**EXP_W-1)-1:0]     din,
  input  logic [1:0]                           mode,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 sign_o,
  output logic [EXP_W-1:0]                     exp_o,
  output logic [FRAC_W-1:0]                    frac_o,
  output logic                                 ovf_o,
  output logic                                 inexact_o
);

  localparam int EXP_MAX = 2**EXP_W - 1;
  localparam int IN_W    = 1 + FRAC_W + EXP_MAX;
  localparam logic [EXP_W:0] E_MAX = (EXP_W+1)'(EXP_MAX);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_sign;
  logic [IN_W-1:0]     r_w;
  logic [EXP_W:0]      r_e;
  logic                r_r;
  logic                r_s;
  logic [1:0]          r_mode;
  logic                r_sign_o;
  logic [EXP_W-1:0]    r_exp_o;
  logic [FRAC_W-1:0]   r_frac_o;
  logic                r_ovf_o;
  logic                r_inx_o;

  logic [IN_W-1:0]     w_abs;
  logic [FRAC_W-1:0]   w_f;
  logic                w_up;
  logic [FRAC_W-1:0]   w_frac_n;
  logic [EXP_W-1:0]    w_exp_n;
  logic                w_ovf_n;
  logic                w_inx_n;

  // Magnitude of the incoming sample; the most-negative value maps to 2**(IN_W-1) unsigned.
  always_comb begin
    w_abs = din[IN_W-1] ? (~din + IN_W'(1)) : din;
  end

  // Rounding decision and carry/saturation handling on the normalised significand.
  always_comb begin
    w_f      = r_w[FRAC_W-1:0];
    w_frac_n = w_f;
    w_exp_n  = r_e[EXP_W-1:0];
    w_ovf_n  = 1'b0;
    w_inx_n  = r_r | r_s;
    case (r_mode)
      2'b00:   w_up = 1'b0;
      2'b10:   w_up = r_r & (r_s | w_f[0]);
      default: w_up = r_r;
    endcase
    if (r_e > E_MAX) begin
      w_frac_n = '1;
      w_exp_n  = E_MAX[EXP_W-1:0];
      w_ovf_n  = 1'b1;
      w_inx_n  = 1'b1;
    end else if (w_up) begin
      if (w_f != '1) begin
        w_frac_n = w_f + FRAC_W'(1);
      end else if (r_e < E_MAX) begin
        // Significand carried out: renormalise to 100..0 and bump the exponent.
        w_frac_n = {1'b1, {(FRAC_W-1){1'b0}}};
        w_exp_n  = EXP_W'(r_e + (EXP_W+1)'(1));
      end else begin
        w_frac_n = '1;
        w_exp_n  = E_MAX[EXP_W-1:0];
        w_ovf_n  = 1'b1;
        w_inx_n  = 1'b1;
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_w         <= '0;
      r_e         <= '0;
      r_r         <= 1'b0;
      r_s         <= 1'b0;
      r_mode      <= '0;
      r_sign_o    <= 1'b0;
      r_exp_o     <= '0;
      r_frac_o    <= '0;
      r_ovf_o     <= 1'b0;
      r_inx_o     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign     <= din[IN_W-1];
            r_w        <= w_abs;
            r_mode     <= mode;
            r_e        <= '0;
            r_r        <= 1'b0;
            r_s        <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_NORM;
          end
        end
        S_NORM: begin
          // One right shift per cycle until the value fits in FRAC_W bits.
          if (|r_w[IN_W-1:FRAC_W]) begin
            r_s <= r_s | r_r;
            r_r <= r_w[0];
            r_w <= r_w >> 1;
            r_e <= r_e + (EXP_W+1)'(1);
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_sign_o    <= r_sign;
          r_exp_o     <= w_exp_n;
          r_frac_o    <= w_frac_n;
          r_ovf_o     <= w_ovf_n;
          r_inx_o     <= w_inx_n;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sign_o    = r_sign_o;
  assign exp_o     = r_exp_o;
  assign frac_o    = r_frac_o;
  assign ovf_o     = r_ovf_o;
  assign inexact_o = r_inx_o;

endmodule

// File: tb/tb_fp_round_seq.sv
// tb/tb_fp_round_seq.sv - self-checking bench for fp_round_seq
module tb_fp_round_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] din;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic        sign_o;
  logic [2:0]  exp_o;
  logic [3:0]  frac_o;
  logic        ovf_o;
  logic        inexact_o;

  int checks = 0;
  int errors = 0;

  fp_round_seq #(.FRAC_W(4), .EXP_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sign_o(sign_o), .exp_o(exp_o), .frac_o(frac_o), .ovf_o(ovf_o),
    .inexact_o(inexact_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] din;
    logic [1:0]  mode;
    logic        sign;
    logic [2:0]  exp;
    logic [3:0]  frac;
    logic        ovf;
    logic        inx;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value = frac * 2^exp derived arithmetically from the magnitude.
  function automatic vec_t model(input logic [11:0] d, input logic [1:0] m);
    vec_t r;
    int v, mag, n, f, rem, half, e;
    bit up;
    v    = $signed(d);
    mag  = (v < 0) ? -v : v;
    n    = 0;
    while ((mag >> n) >= 16) n++;
    f    = mag >> n;
    rem  = mag - (f << n);
    half = (n > 0) ? (1 << (n - 1)) : 0;
    case (m)
      2'd0:    up = 1'b0;
      2'd2:    up = (n > 0) && ((rem > half) || (rem == half && (f % 2) == 1));
      default: up = (n > 0) && (rem >= half);
    endcase
    e = n;
    if (up) f++;
    if (f == 16) begin f = 8; e++; end
    r.din  = d;
    r.mode = m;
    r.sign = d[11];
    r.lat  = n + 2;
    if (e > 7) begin
      r.exp = 3'd7; r.frac = 4'hF; r.ovf = 1'b1; r.inx = 1'b1;
    end else begin
      r.exp = 3'(e); r.frac = 4'(f); r.ovf = 1'b0; r.inx = (rem != 0);
    end
    return r;
  endfunction

  task automatic do_sample(input logic [11:0] d, input logic [1:0] m, input int hold, input bit poke,
                           output vec_t got);
    int  n;
    bit  busy_ok, stable;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_idle", in_ready, 1);
    din = d; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; din = 12'($urandom); mode = 2'($urandom);
    got.lat = 0; busy_ok = 1'b1;
    while (!out_valid && got.lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      if (poke) begin in_valid = 1'b1; din = 12'h7FF; mode = 2'd1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      got.lat++;
    end
    chk("out_valid_rise", out_valid, 1);
    chk("in_ready_busy", {busy_ok, in_ready}, 2'b10);
    got.din = d; got.mode = m;
    got.sign = sign_o; got.exp = exp_o; got.frac = frac_o; got.ovf = ovf_o; got.inx = inexact_o;
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || sign_o !== got.sign || exp_o !== got.exp ||
            frac_o !== got.frac || ovf_o !== got.ovf || inexact_o !== got.inx) stable = 1'b0;
      end
      chk("hold_stable", stable, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  task automatic cmp(input string tag, input vec_t got, input vec_t exp);
    chk({tag, "_sign"}, got.sign, exp.sign);
    chk({tag, "_exp"},  got.exp,  exp.exp);
    chk({tag, "_frac"}, got.frac, exp.frac);
    chk({tag, "_ovf"},  got.ovf,  exp.ovf);
    chk({tag, "_inx"},  got.inx,  exp.inx);
    chk({tag, "_lat"},  got.lat,  exp.lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    vec_t got;
    bit   quiet;

    tbl[0]  = '{12'h02E, 2'd1, 1'b0, 3'd2, 4'b1100, 1'b0, 1'b1, 4};
    tbl[1]  = '{12'h02A, 2'd2, 1'b0, 3'd2, 4'b1010, 1'b0, 1'b1, 4};
    tbl[2]  = '{12'h02A, 2'd1, 1'b0, 3'd2, 4'b1011, 1'b0, 1'b1, 4};
    tbl[3]  = '{12'h02A, 2'd0, 1'b0, 3'd2, 4'b1010, 1'b0, 1'b1, 4};
    tbl[4]  = '{12'h02A, 2'd3, 1'b0, 3'd2, 4'b1011, 1'b0, 1'b1, 4};
    tbl[5]  = '{12'h07C, 2'd1, 1'b0, 3'd4, 4'b1000, 1'b0, 1'b1, 5};
    tbl[6]  = '{12'h7FF, 2'd1, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b1, 9};
    tbl[7]  = '{12'h800, 2'd0, 1'b1, 3'd7, 4'b1111, 1'b1, 1'b1, 10};
    tbl[8]  = '{12'h005, 2'd0, 1'b0, 3'd0, 4'b0101, 1'b0, 1'b0, 2};
    tbl[9]  = '{12'hFD2, 2'd1, 1'b1, 3'd2, 4'b1100, 1'b0, 1'b1, 4};
    tbl[10] = '{12'h000, 2'd1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 2};
    tbl[11] = '{12'h02E, 2'd2, 1'b0, 3'd2, 4'b1100, 1'b0, 1'b1, 4};
    tbl[12] = '{12'h7FF, 2'd0, 1'b0, 3'd7, 4'b1111, 1'b0, 1'b1, 9};

    rst = 1'b1; in_valid = 1'b0; din = '0; mode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", {sign_o, exp_o, frac_o, ovf_o, inexact_o}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      do_sample(tbl[i].din, tbl[i].mode, 0, 1'b0, got);
      cmp($sformatf("vec%0d", i), got, tbl[i]);
    end

    // Backpressure for 5 cycles with ignored in_valid pulses while busy.
    do_sample(12'h02E, 2'd1, 5, 1'b1, got);
    cmp("hold", got, tbl[0]);

    // Reset during NORM aborts the sample.
    din = 12'h7FF; mode = 2'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_data", {sign_o, exp_o, frac_o, ovf_o, inexact_o}, 0);
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) quiet = 1'b0;
    end
    chk("abort_no_output", quiet, 1);

    for (int i = 0; i < 150; i++) begin
      logic [11:0] d;
      logic [1:0]  m;
      d = 12'($urandom);
      if (i % 3 == 0) d = 12'($urandom_range(0, 300));
      m = 2'($urandom_range(0, 3));
      do_sample(d, m, $urandom_range(0, 2), 1'($urandom), got);
      cmp($sformatf("rand%0d_%03h_m%0d", i, d, m), got, model(d, m));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
